// File: rtl/uart_tx_fifo_drain.sv
// uart_tx_fifo_drain: pops one word per frame from a sync FIFO and sends it
// LSB-first as a UART frame on tx (start, data, [parity], stop bits).
// Ports: clk, rst_n (async, active-low), tx_en, fifo_empty, fifo_data,
// fifo_rd_en (single-cycle pop), tx (idle high), busy, frame_done.
// Optional parity bit enabled by defining UART_TX_PARITY_EN (adds PARITY_ODD).
module uart_tx_fifo_drain #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 434,
    parameter int STOP_BITS    = 1
`ifdef UART_TX_PARITY_EN
    ,
    parameter bit PARITY_ODD   = 1'b0
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tx_en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int BW   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int NMAX = (DATA_WIDTH > STOP_BITS) ? DATA_WIDTH : STOP_BITS;
    localparam int NW   = (NMAX > 1) ? $clog2(NMAX) : 1;

    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);
    localparam logic [NW-1:0] DATA_LAST = NW'(DATA_WIDTH - 1);
    localparam logic [NW-1:0] STOP_LAST = NW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t                  state_q, state_d;
    logic [BW-1:0]           baud_q, baud_d;
    logic [NW-1:0]           bit_q, bit_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    tx_q, tx_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic                    par_q, par_d;
`endif

    logic                    baud_end;
    logic [BW-1:0]           baud_nx;
    logic [DATA_WIDTH-1:0]   shift_nx;

    // Gated by rst_n so no word is popped (and lost) while held in reset.
    assign fifo_rd_en = rst_n && (state_q == S_IDLE) && tx_en && !fifo_empty;

    assign baud_end = (baud_q == BAUD_LAST);
    assign baud_nx  = baud_end ? '0 : baud_q + 1'b1;
    assign shift_nx = shift_q >> 1;

    // tx/busy/frame_done are computed one cycle ahead so they leave flops.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (fifo_rd_en) begin
                    state_d = S_FETCH;
                    busy_d  = 1'b1;
                end
            end
            S_FETCH: begin
                shift_d = fifo_data;
`ifdef UART_TX_PARITY_EN
                par_d   = (^fifo_data) ^ PARITY_ODD;
`endif
                baud_d  = '0;
                state_d = S_START;
                tx_d    = 1'b0;
            end
            S_START: begin
                baud_d = baud_nx;
                if (baud_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            S_DATA: begin
                baud_d = baud_nx;
                if (baud_end) begin
                    shift_d = shift_nx;
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = par_q;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                        tx_d  = shift_nx[0];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                baud_d = baud_nx;
                if (baud_end) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                baud_d = baud_nx;
                // Pulse lands on the final cycle of the final stop bit.
                if (baud_q == BAUD_PRE && bit_q == STOP_LAST) begin
                    done_d = 1'b1;
                end
                if (baud_end) begin
                    if (bit_q == STOP_LAST) begin
                        bit_d   = '0;
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
                bit_d   = '0;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Testbench for uart_tx_fifo_drain: FIFO model, per-cycle frame model,
// vector table of known frames and hand-written corner sequences.
module tb_uart_tx_fifo_drain;

    localparam int W  = 8;
    localparam int C  = 4;
    localparam int SB = 1;
`ifdef UART_TX_PARITY_EN
    localparam bit PODD = 1'b0;
    localparam int NB   = 2 + W + SB;
`else
    localparam int NB   = 1 + W + SB;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         tx_en = 1'b0;
    logic [W-1:0] fifo_data = '0;
    logic         fifo_empty;
    logic         fifo_rd_en;
    logic         tx;
    logic         busy;
    logic         frame_done;

    logic [W-1:0] mem [256];
    int           n_push = 0;
    int           n_pop = 0;
    int           checks = 0;
    int           errors = 0;
    int           rd_cnt = 0;

    assign fifo_empty = (n_push <= n_pop);

    always #5 clk = ~clk;

    uart_tx_fifo_drain #(
        .DATA_WIDTH  (W),
        .CLKS_PER_BIT(C),
        .STOP_BITS   (SB)
`ifdef UART_TX_PARITY_EN
        ,
        .PARITY_ODD  (PODD)
`endif
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tx_en     (tx_en),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .fifo_rd_en(fifo_rd_en),
        .tx        (tx),
        .busy      (busy),
        .frame_done(frame_done)
    );

    // FIFO read port: data valid the cycle after the pop.
    always @(posedge clk) begin
        if (rst_n && fifo_rd_en) begin
            fifo_data <= mem[n_pop & 255];
            n_pop     <= n_pop + 1;
        end
    end

    typedef struct {
        logic [W-1:0] data;
        logic [0:9]   seq;
        logic         par;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s t=%0t got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] b);
        mem[n_push & 255] = b;
        n_push++;
    endtask

    function automatic logic exp_bit(input vec_t v, input int k);
`ifdef UART_TX_PARITY_EN
        if (k <= W) return v.seq[k];
        if (k == W + 1) return v.par ^ PODD;
        return 1'b1;
`else
        return v.seq[k];
`endif
    endfunction

    task automatic wait_rd();
        bit seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (fifo_rd_en) begin
                seen = 1'b1;
                break;
            end
        end
        chk("wait_rd_en", 32'(seen), 32'd1);
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (frame_done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("wait_frame_done", 32'(seen), 32'd1);
    endtask

    task automatic wait_idle();
        bit seen = 1'b0;
        for (int k = 0; k < 6000; k++) begin
            @(negedge clk);
            if (!busy && fifo_empty && !fifo_rd_en) begin
                seen = 1'b1;
                break;
            end
        end
        chk("wait_idle", 32'(seen), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int r0;
        int n;
        bit saw;

        tbl[0] = '{8'hA5, 10'b0101001011, 1'b0};
        tbl[1] = '{8'h00, 10'b0000000001, 1'b0};
        tbl[2] = '{8'hFF, 10'b0111111111, 1'b0};
        tbl[3] = '{8'h07, 10'b0111000001, 1'b1};
        tbl[4] = '{8'h3C, 10'b0001111001, 1'b0};
        tbl[5] = '{8'h5A, 10'b0010110101, 1'b0};
        tbl[6] = '{8'h81, 10'b0100000011, 1'b0};

        // Reference model: every cycle compares {tx,busy,frame_done} with a
        // schedule built from the popped word when a pop is seen.
        fork
            begin : mon
                logic [2:0] sched [$];
                logic [2:0] e;
                logic [W-1:0] b;
                logic bv;
                bit idle_now;
                forever begin
                    @(negedge clk);
                    if (!rst_n) begin
                        sched.delete();
                        chk("rst_tx", 32'(tx), 32'd1);
                        chk("rst_busy", 32'(busy), 32'd0);
                        chk("rst_done", 32'(frame_done), 32'd0);
                        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
                    end else begin
                        idle_now = (sched.size() == 0);
                        e = idle_now ? 3'b100 : sched.pop_front();
                        chk("model_tx", 32'(tx), 32'(e[2]));
                        chk("model_busy", 32'(busy), 32'(e[1]));
                        chk("model_done", 32'(frame_done), 32'(e[0]));
                        chk("model_rd_en", 32'(fifo_rd_en),
                            32'(idle_now && tx_en && (n_push > n_pop)));
                        if (fifo_rd_en) begin
                            rd_cnt++;
                            b = mem[n_pop & 255];
                            sched.push_back(3'b110);
                            for (int j = 0; j < NB; j++) begin
                                if (j == 0) bv = 1'b0;
                                else if (j <= W) bv = b[j-1];
`ifdef UART_TX_PARITY_EN
                                else if (j == W + 1) bv = (^b) ^ PODD;
`endif
                                else bv = 1'b1;
                                for (int c = 0; c < C; c++)
                                    sched.push_back({bv, 1'b1,
                                        (j == NB - 1 && c == C - 1)});
                            end
                        end
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        step();
        rst_n = 1'b1;
        tx_en = 1'b1;

        r0 = rd_cnt;
        saw = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (fifo_rd_en || busy || !tx) saw = 1'b1;
        end
        chk("empty_idle", 32'(saw), 32'd0);
        chk("empty_no_pop", 32'(rd_cnt - r0), 32'd0);

        for (int i = 0; i < 7; i++) begin
            step();
            push(tbl[i].data);
            r0 = rd_cnt;
            wait_rd();
            @(negedge clk);
            chk("vec_fetch_tx", 32'(tx), 32'd1);
            chk("vec_fetch_busy", 32'(busy), 32'd1);
            for (int k = 0; k < NB; k++) begin
                repeat (2) @(negedge clk);
                chk("vec_bit", 32'(tx), 32'(exp_bit(tbl[i], k)));
                chk("vec_busy", 32'(busy), 32'd1);
                repeat (C - 2) @(negedge clk);
            end
            wait_idle();
            chk("vec_one_pop", 32'(rd_cnt - r0), 32'd1);
        end

        step();
        push(8'h00);
        push(8'hFF);
        r0 = rd_cnt;
        wait_done();
        n = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n++;
            if (!tx) break;
        end
        chk("b2b_gap", 32'(n), 32'd3);
        wait_done();
        wait_idle();
        chk("b2b_two_pops", 32'(rd_cnt - r0), 32'd2);

        step();
        push(8'h3C);
        push(8'h11);
        push(8'h22);
        r0 = rd_cnt;
        wait_rd();
        repeat (1 + C + 2 * C) @(negedge clk);
        chk("txen_in_frame", 32'(busy), 32'd1);
        step();
        tx_en = 1'b0;
        wait_done();
        repeat (20) @(negedge clk);
        chk("txen_one_pop", 32'(rd_cnt - r0), 32'd1);
        chk("txen_left", 32'(n_push - n_pop), 32'd2);
        chk("txen_idle", 32'(busy), 32'd0);
        step();
        tx_en = 1'b1;
        wait_idle();

        step();
        push(8'h5A);
        push(8'h81);
        r0 = rd_cnt;
        wait_rd();
        @(negedge clk);
        repeat (4 * C + 2) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        chk("pre_rst_tx", 32'(tx), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_tx", 32'(tx), 32'd1);
        chk("async_rst_busy", 32'(busy), 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        wait_done();
        wait_idle();
        chk("rst_pops", 32'(rd_cnt - r0), 32'd2);
        chk("rst_drained", 32'(n_push - n_pop), 32'd0);

        for (int i = 0; i < 40; i++) begin
            step();
            if ($urandom_range(0, 2) == 0) push(W'($urandom));
            if ($urandom_range(0, 5) == 0) push(W'($urandom));
            tx_en = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(0, 50)) step();
        end
        step();
        tx_en = 1'b1;
        wait_idle();
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
